// File: rtl/la_capture_fsm.sv
// Capture sequencer for the logic analyzer sample memory.
//
// Consumes the combined trigger and drives the write strobe / write address
// of the circular sample memory. Handles pre-trigger positioning and stops
// once the buffer holds exactly one full capture window (SAMPLE_DEPTH
// samples, oldest at read_pointer_o).
//
// Ports:
//   clk, rst                 system clock, synchronous active-high reset
//   trig                     combined trigger, sampled every clk
//   addr_i/wdata_i/rdata_i/
//   rw_i/valid_i             daisy-chained register bus in
//   addr_o/wdata_o/rdata_o/
//   rw_o/valid_o             register bus out (registered, 1-cycle latency)
//   write_enable_o           sample memory write strobe
//   write_pointer_o          sample memory write address
//   read_pointer_o           address of the oldest valid sample
//
// Register map (offsets from BASE_ADDR):
//   0 STATE (RO), 1 TRIGGER_MODE, 2 TRIGGER_LOC, 3 REQUEST_START,
//   4 REQUEST_STOP, 5 READ_POINTER (RO), 6 WRITE_POINTER (RO)
module la_capture_fsm #(
  parameter int unsigned BASE_ADDR    = 0,
  parameter int unsigned SAMPLE_DEPTH = 4096
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            trig,
  input  logic [15:0]                     addr_i,
  input  logic [15:0]                     wdata_i,
  input  logic [15:0]                     rdata_i,
  input  logic                            rw_i,
  input  logic                            valid_i,
  output logic [15:0]                     addr_o,
  output logic [15:0]                     wdata_o,
  output logic [15:0]                     rdata_o,
  output logic                            rw_o,
  output logic                            valid_o,
  output logic                            write_enable_o,
  output logic [$clog2(SAMPLE_DEPTH)-1:0] write_pointer_o,
  output logic [$clog2(SAMPLE_DEPTH)-1:0] read_pointer_o
);

  localparam int unsigned     AW      = $clog2(SAMPLE_DEPTH);
  localparam logic [16:0]     BASE17  = 17'(BASE_ADDR);
  localparam logic [AW-1:0]   LOC_MAX = AW'(SAMPLE_DEPTH - 1);
  localparam logic [AW-1:0]   PTR_ONE = AW'(1);

  typedef enum logic [2:0] {
    IDLE             = 3'd0,
    MOVE_TO_POSITION = 3'd1,
    IN_POSITION      = 3'd2,
    CAPTURING        = 3'd3,
    CAPTURED         = 3'd4
  } state_t;

  state_t        state, state_n;
  logic [AW-1:0] wp, wp_n;
  logic [AW-1:0] rp, rp_n;

  logic          trigger_mode;
  logic [AW-1:0] trigger_loc;
  logic          request_start;
  logic          request_stop;

  logic [16:0]   offset;
  logic [2:0]    reg_sel;
  logic          in_range;
  logic          bus_wr;
  logic          bus_rd;
  logic          start_edge;
  logic          stop_edge;
  logic [AW-1:0] loc_wdata;
  logic [15:0]   reg_rdata;

  // Bus decode. The 17-bit subtraction keeps addresses below BASE_ADDR
  // from aliasing into the window.
  always_comb begin
    offset     = {1'b0, addr_i} - BASE17;
    reg_sel    = offset[2:0];
    in_range   = (offset <= 17'd6);
    bus_wr     = valid_i & rw_i & in_range;
    bus_rd     = valid_i & ~rw_i & in_range;
    start_edge = bus_wr && (reg_sel == 3'd3) && wdata_i[0] && !request_start
                 && (state == IDLE);
    stop_edge  = bus_wr && (reg_sel == 3'd4) && wdata_i[0] && !request_stop;
    if ({16'd0, wdata_i} > (SAMPLE_DEPTH - 1)) begin
      loc_wdata = LOC_MAX;
    end else begin
      loc_wdata = wdata_i[AW-1:0];
    end
  end

  always_comb begin
    reg_rdata = '0;
    case (reg_sel)
      3'd0:    reg_rdata = 16'(state);
      3'd1:    reg_rdata = 16'(trigger_mode);
      3'd2:    reg_rdata = 16'(trigger_loc);
      3'd3:    reg_rdata = 16'(request_start);
      3'd4:    reg_rdata = 16'(request_stop);
      3'd5:    reg_rdata = 16'(rp);
      3'd6:    reg_rdata = 16'(wp);
      default: reg_rdata = '0;
    endcase
  end

  // Bus pipeline stage and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_o        <= '0;
      wdata_o       <= '0;
      rdata_o       <= '0;
      rw_o          <= 1'b0;
      valid_o       <= 1'b0;
      trigger_mode  <= 1'b0;
      trigger_loc   <= '0;
      request_start <= 1'b0;
      request_stop  <= 1'b0;
    end else begin
      addr_o  <= addr_i;
      wdata_o <= wdata_i;
      rw_o    <= rw_i;
      valid_o <= valid_i;
      rdata_o <= bus_rd ? reg_rdata : rdata_i;
      if (bus_wr) begin
        case (reg_sel)
          3'd1: if (state == IDLE) trigger_mode <= wdata_i[0];
          3'd2: if (state == IDLE) trigger_loc  <= loc_wdata;
          3'd3: request_start <= wdata_i[0];
          3'd4: request_stop  <= wdata_i[0];
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      wp    <= '0;
      rp    <= '0;
    end else begin
      state <= state_n;
      wp    <= wp_n;
      rp    <= rp_n;
    end
  end

  always_comb begin
    state_n = state;
    wp_n    = wp;
    rp_n    = rp;
    case (state)
      IDLE: begin
        if (start_edge) begin
          wp_n = '0;
          rp_n = '0;
          if (trigger_mode) begin
            state_n = CAPTURING;
          end else if (trigger_loc == '0) begin
            state_n = IN_POSITION;
          end else begin
            state_n = MOVE_TO_POSITION;
          end
        end
      end
      MOVE_TO_POSITION: begin
        wp_n = wp + PTR_ONE;
        if (wp == (trigger_loc - PTR_ONE)) state_n = IN_POSITION;
      end
      IN_POSITION: begin
        // rp trails wp by TRIGGER_LOC until the trigger sample, then freezes.
        wp_n = wp + PTR_ONE;
        if (trig) begin
          state_n = CAPTURING;
        end else begin
          rp_n = rp + PTR_ONE;
        end
      end
      CAPTURING: begin
        if ((wp + PTR_ONE) == rp) begin
          state_n = CAPTURED;
        end else begin
          wp_n = wp + PTR_ONE;
        end
      end
      CAPTURED: ;
      default: state_n = IDLE;
    endcase
    // Stop overrides any transition and freezes the pointers for readout.
    if (stop_edge) begin
      state_n = IDLE;
      wp_n    = wp;
      rp_n    = rp;
    end
  end

  always_comb begin
    write_enable_o  = (state == MOVE_TO_POSITION) || (state == IN_POSITION)
                      || (state == CAPTURING);
    write_pointer_o = wp;
    read_pointer_o  = rp;
  end

endmodule

// File: tb/tb_la_capture_fsm.sv
// Bench for la_capture_fsm: stimulus pushes expectations into queues, a
// negedge monitor pops and compares bus outputs and capture outputs.
module tb_la_capture_fsm;

  localparam int BASE = 4;
  localparam int D    = 8;
  localparam int AW   = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          trig;
  logic [15:0]   addr_i, wdata_i, rdata_i;
  logic          rw_i, valid_i;
  logic [15:0]   addr_o, wdata_o, rdata_o;
  logic          rw_o, valid_o;
  logic          write_enable_o;
  logic [AW-1:0] write_pointer_o, read_pointer_o;

  always #5 clk = ~clk;

  la_capture_fsm #(.BASE_ADDR(BASE), .SAMPLE_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .trig(trig),
    .addr_i(addr_i), .wdata_i(wdata_i), .rdata_i(rdata_i),
    .rw_i(rw_i), .valid_i(valid_i),
    .addr_o(addr_o), .wdata_o(wdata_o), .rdata_o(rdata_o),
    .rw_o(rw_o), .valid_o(valid_o),
    .write_enable_o(write_enable_o),
    .write_pointer_o(write_pointer_o), .read_pointer_o(read_pointer_o)
  );

  typedef struct {
    int          due;
    logic [15:0] addr, wdata, rdata;
    logic        rw, valid;
  } bus_exp_t;

  typedef struct {
    int   due;
    logic we;
    int   wp, rp;
  } cap_exp_t;

  bus_exp_t bq[$];
  cap_exp_t cq[$];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: a capture is described by its start cycle and config;
  // state and pointers at any later cycle follow from arithmetic on c.
  bit active = 0;
  int s_cyc = 0, end_c = 0;
  int cap_mode = 0, cap_L = 0, cap_k = 0, cap_n = 0;
  int m_mode = 0, m_loc = 0, m_start = 0, m_stop = 0;
  int k_next = -1;

  function automatic void cap_at(input int c, output int st, output int wp, output int rp);
    if (cap_mode == 1) begin
      rp = 0;
      if (c < D) begin st = 3; wp = c; end
      else begin st = 4; wp = D - 1; end
    end else if (c < cap_L) begin
      st = 1; wp = c % D; rp = 0;
    end else if (cap_k < 0 || c <= cap_L + cap_k) begin
      st = 2; wp = c % D; rp = (c - cap_L) % D;
    end else begin
      rp = cap_k % D;
      if (c < cap_n) begin st = 3; wp = c % D; end
      else begin st = 4; wp = (cap_n - 1) % D; end
    end
  endfunction

  function automatic void model_at(input int x, output int st, output int wp, output int rp);
    int c;
    if (!active) begin
      st = 0; wp = 0; rp = 0;
    end else begin
      c = x - s_cyc;
      if (c > end_c) begin
        cap_at(end_c, st, wp, rp);
        st = 0;
      end else begin
        cap_at(c, st, wp, rp);
      end
    end
  endfunction

  function automatic int reg_val(input int off, input int st, input int wp, input int rp);
    case (off)
      0: return st;
      1: return m_mode;
      2: return m_loc;
      3: return m_start;
      4: return m_stop;
      5: return rp;
      6: return wp;
      default: return 0;
    endcase
  endfunction

  task automatic start_capture();
    int n;
    active   = 1;
    s_cyc    = cyc + 1;
    end_c    = 1 << 30;
    cap_mode = m_mode;
    cap_L    = m_loc;
    cap_k    = (m_mode == 1) ? 0 : k_next;
    if (cap_mode == 0 && cap_k >= 0) begin
      // last write lands just below the oldest sample (rp = k)
      n = cap_L + cap_k + 1;
      while (n % D != (cap_k + D - 1) % D) n++;
      cap_n = n + 1;
    end
  endtask

  // Drive one cycle: bus inputs are already set by the caller.
  task automatic step();
    int st, wp, rp, c, off;
    bit inr;
    bus_exp_t be;
    cap_exp_t ce;
    model_at(cyc, st, wp, rp);
    c = cyc - s_cyc;
    if (st == 2) trig = (cap_k >= 0) && (c - cap_L == cap_k);
    else         trig = 1'($urandom);
    rdata_i = 16'($urandom);

    ce.due = cyc; ce.we = (st >= 1 && st <= 3); ce.wp = wp; ce.rp = rp;
    cq.push_back(ce);

    off = int'(addr_i) - BASE;
    inr = (off >= 0 && off <= 6);
    be.due = cyc + 1;
    if (rst) begin
      be.addr = '0; be.wdata = '0; be.rdata = '0; be.rw = 1'b0; be.valid = 1'b0;
    end else begin
      be.addr = addr_i; be.wdata = wdata_i; be.rw = rw_i; be.valid = valid_i;
      be.rdata = (valid_i && !rw_i && inr) ? 16'(reg_val(off, st, wp, rp)) : rdata_i;
    end
    bq.push_back(be);

    if (rst) begin
      active = 0; m_mode = 0; m_loc = 0; m_start = 0; m_stop = 0;
    end else if (valid_i && rw_i && inr) begin
      case (off)
        1: if (st == 0) m_mode = int'(wdata_i[0]);
        2: if (st == 0) m_loc = (int'(wdata_i) > D - 1) ? D - 1 : int'(wdata_i);
        3: begin
          if (wdata_i[0] && m_start == 0 && st == 0) start_capture();
          m_start = int'(wdata_i[0]);
        end
        4: begin
          if (wdata_i[0] && m_stop == 0 && active && c <= end_c) end_c = c;
          m_stop = int'(wdata_i[0]);
        end
        default: ;
      endcase
    end
    @(posedge clk); #1;
  endtask

  task automatic idle();
    valid_i = 1'b0; rw_i = 1'($urandom);
    addr_i = 16'($urandom); wdata_i = 16'($urandom);
    step();
  endtask

  task automatic rd(input int off);
    valid_i = 1'b1; rw_i = 1'b0; addr_i = 16'(BASE + off); wdata_i = 16'($urandom);
    step();
    valid_i = 1'b0;
  endtask

  task automatic wr(input int off, input int data);
    valid_i = 1'b1; rw_i = 1'b1; addr_i = 16'(BASE + off); wdata_i = 16'(data);
    step();
    valid_i = 1'b0;
  endtask

  // Monitor: compares whatever the DUT presents in the cycle an entry is due.
  always @(negedge clk) begin
    bus_exp_t be;
    cap_exp_t ce;
    if (bq.size() > 0 && bq[0].due == cyc) begin
      be = bq.pop_front();
      checks++;
      if (rdata_o !== be.rdata) begin
        errors++;
        $display("FAIL rdata cyc=%0d got=%h exp=%h", cyc, rdata_o, be.rdata);
      end
      checks++;
      if ({addr_o, wdata_o, rw_o, valid_o} !== {be.addr, be.wdata, be.rw, be.valid}) begin
        errors++;
        $display("FAIL bus_pass cyc=%0d got addr=%h wdata=%h rw=%b valid=%b exp addr=%h wdata=%h rw=%b valid=%b",
                 cyc, addr_o, wdata_o, rw_o, valid_o, be.addr, be.wdata, be.rw, be.valid);
      end
    end
    if (cq.size() > 0 && cq[0].due == cyc) begin
      ce = cq.pop_front();
      checks++;
      if (write_enable_o !== ce.we || write_pointer_o !== AW'(ce.wp)
          || read_pointer_o !== AW'(ce.rp)) begin
        errors++;
        $display("FAIL capture cyc=%0d got we=%b wp=%0d rp=%0d exp we=%b wp=%0d rp=%0d",
                 cyc, write_enable_o, write_pointer_o, read_pointer_o, ce.we, ce.wp, ce.rp);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r, off;
    rst = 1'b1; trig = 1'b0; valid_i = 1'b0; rw_i = 1'b0;
    addr_i = '0; wdata_i = '0; rdata_i = '0;
    @(posedge clk); #1;
    step(); step();
    rst = 1'b0;

    // reset values and out-of-window passthrough
    for (int i = 0; i <= 7; i++) rd(i);
    rd(-1);

    // TRIGGER_LOC clamp
    wr(2, 100); rd(2);

    // triggered, loc=3, trig never asserted: parks in IN_POSITION
    wr(2, 3); wr(1, 0); k_next = -1; wr(3, 1);
    for (int i = 0; i < 12; i++) rd((i % 2 == 0) ? 0 : 5);
    wr(4, 1); rd(0); rd(5); rd(6);
    wr(3, 1); idle(); idle(); rd(0);
    wr(3, 0); wr(4, 0);

    // triggered, loc=3, trigger in 2nd IN_POSITION cycle; config locked
    k_next = 1; wr(3, 1);
    for (int i = 0; i < 6; i++) rd(0);
    wr(2, 5);
    for (int i = 0; i < 8; i++) rd(i % 7);
    rd(2); rd(5); rd(0);
    wr(3, 0);

    // immediate mode: D writes from 0, rp stays 0
    wr(4, 1); wr(4, 0); wr(1, 1); wr(3, 1);
    for (int i = 0; i < 12; i++) rd((i % 3 == 0) ? 0 : ((i % 3 == 1) ? 5 : 6));
    wr(4, 1); wr(4, 0); wr(3, 0); wr(1, 0);

    // stop in the middle of CAPTURING
    wr(2, 2); k_next = 0; wr(3, 1);
    for (int i = 0; i < 5; i++) rd(0);
    wr(4, 1); rd(0); rd(5); rd(6); idle();
    wr(4, 0); wr(3, 0);

    // reset in the middle of a capture
    k_next = -1; wr(3, 1);
    idle(); idle(); idle(); idle();
    rst = 1'b1; idle(); rst = 1'b0;
    for (int i = 0; i <= 6; i++) rd(i);

    // randomized bus traffic
    for (int i = 0; i < 1500; i++) begin
      k_next = ($urandom % 4 == 0) ? -1 : int'($urandom_range(0, 9));
      r = int'($urandom % 100);
      if (r < 1) begin
        rst = 1'b1; idle(); rst = 1'b0;
      end else if (r < 40) begin
        off = int'($urandom_range(0, 9)) - 1;
        if ($urandom % 2 == 0) begin
          rd(off);
        end else if (off == 2) begin
          wr(off, int'($urandom_range(0, 20)));
        end else if ($urandom % 8 == 0) begin
          wr(off, int'($urandom % 65536));
        end else begin
          wr(off, int'($urandom_range(0, 1)));
        end
      end else begin
        idle();
      end
    end

    idle(); idle();
    @(negedge clk); #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
